// File: rtl/booth_multiplier_param.sv
// Multi-cycle radix-4 Booth multiplier, WIDTH-parametrised, signed/unsigned per operation.
// Optional early termination with a single-cycle alignment shift when MULT_EARLYOUT_EN is defined.
module booth_multiplier_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;       // extended operand width
  localparam int AW   = WIDTH + 3;       // accumulator / adder width
  localparam int PW   = AW + EW + 1;     // {acc, multiplier, pending}
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] ITER_C = CW'(ITER);

`ifdef MULT_EARLYOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ALIGN, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [EW-1:0]   a_q;
  logic [PW-1:0]   prod_q;
  logic            signed_q;

  logic [EW-1:0]   a_ext;
  logic [EW-1:0]   b_ext;
  logic [AW-1:0]   a_w;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   acc_sum;
  logic [PW-1:0]   prod_step;
  logic [WIDTH:0]  top_sig;
  logic            exc_next;

  assign a_ext = ctrl_signed ? {{2{data_operandA[WIDTH-1]}}, data_operandA}
                             : {2'b00, data_operandA};
  assign b_ext = ctrl_signed ? {{2{data_operandB[WIDTH-1]}}, data_operandB}
                             : {2'b00, data_operandB};
  assign a_w   = {a_q[EW-1], a_q};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pp = '0;
    unique case (prod_q[2:0])
      3'b001, 3'b010: pp = a_w;
      3'b011:         pp = a_w << 1;
      3'b100:         pp = -(a_w << 1);
      3'b101, 3'b110: pp = -a_w;
      default:        pp = '0;
    endcase
  end

  // Add into the accumulator field, then arithmetic-shift the whole register by 2.
  assign acc_sum   = prod_q[PW-1 -: AW] + pp;
  assign prod_step = {acc_sum[AW-1], acc_sum[AW-1], acc_sum, prod_q[EW:2]};

  // Product[2W-1:0] lives at prod_q[2W:1] once all multiplier bits are consumed.
  assign top_sig  = prod_q[2*WIDTH:WIDTH];
  assign exc_next = signed_q ? !((&top_sig) || (~|top_sig))
                             : (|prod_q[2*WIDTH:WIDTH+1]);

`ifdef MULT_EARLYOUT_EN
  logic             early_exit;
  logic [CW:0]      shamt;
  logic [PW-1:0]    prod_aligned;

  // Remaining multiplier bits plus the pending bit sit at prod_q[EW-2*cnt:0].
  always_comb begin
    logic all_zero;
    logic all_one;
    all_zero = 1'b1;
    all_one  = 1'b1;
    for (int i = 0; i <= EW; i++) begin
      if (i <= EW - 2 * int'(cnt)) begin
        all_zero = all_zero & ~prod_q[i];
        all_one  = all_one  &  prod_q[i];
      end
    end
    early_exit = (cnt != '0) && (cnt < ITER_C) && (all_zero || all_one);
  end

  assign shamt        = {ITER_C - cnt, 1'b0};
  assign prod_aligned = $signed(prod_q) >>> shamt;
`endif

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      a_q            <= '0;
      prod_q         <= '0;
      signed_q       <= 1'b0;
      data_result    <= '0;
      data_result_hi <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        // Start, restart after abort, or back-to-back start from DONE.
        state    <= S_CALC;
        cnt      <= '0;
        a_q      <= a_ext;
        prod_q   <= {{AW{1'b0}}, b_ext, 1'b0};
        signed_q <= ctrl_signed;
        busy     <= 1'b1;
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_CALC: begin
            if (cnt == ITER_C) begin
              data_result    <= prod_q[WIDTH:1];
              data_result_hi <= prod_q[2*WIDTH:WIDTH+1];
              data_exception <= exc_next;
              data_resultRDY <= 1'b1;
              busy           <= 1'b0;
              state          <= S_DONE;
`ifdef MULT_EARLYOUT_EN
            end else if (early_exit) begin
              prod_q <= prod_aligned;
              state  <= S_ALIGN;
`endif
            end else begin
              prod_q <= prod_step;
              cnt    <= cnt + 1'b1;
            end
          end
`ifdef MULT_EARLYOUT_EN
          S_ALIGN: begin
            data_result    <= prod_q[WIDTH:1];
            data_result_hi <= prod_q[2*WIDTH:WIDTH+1];
            data_exception <= exc_next;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
            state          <= S_DONE;
          end
`endif
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Self-checking bench for booth_multiplier_param (WIDTH=32): directed corner cases plus
// randomized operations against a plain-arithmetic reference model.
module tb_booth_multiplier_param;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH / 2 + 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_signed = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic [31:0] data_result_hi;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  booth_multiplier_param #(.WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_signed    (ctrl_signed),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_result_hi (data_result_hi),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full 2*WIDTH product from ordinary integer multiplication.
  function automatic logic [63:0] model_prod(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = sg ? longint'(signed'(a)) : longint'({32'b0, a});
    sb = sg ? longint'(signed'(b)) : longint'({32'b0, b});
    return 64'(sa * sb);
  endfunction

  function automatic logic model_exc(input logic sg, input logic [63:0] p);
    longint ps;
    ps = longint'(p);
    if (sg) return (ps < -64'sd2147483648) || (ps > 64'sd2147483647);
    return p[63:32] != 32'h0;
  endfunction

  // Edges from the start edge to the RDY cycle.
  function automatic int model_lat(input logic sg, input logic [31:0] b);
    int lat;
    lat = ITER + 1;
`ifdef MULT_EARLYOUT_EN
    begin
      logic [34:0] bits;
      bits = sg ? {b[31], b[31], b, 1'b0} : {2'b00, b, 1'b0};
      for (int k = 1; k < ITER; k++) begin
        logic z;
        logic o;
        z = 1'b1;
        o = 1'b1;
        for (int j = 2 * k; j <= 34; j++) begin
          z = z & ~bits[j];
          o = o & bits[j];
        end
        if (z || o) begin
          lat = k + 2;
          break;
        end
      end
    end
`endif
    return lat;
  endfunction

  // Caller is positioned between edges; the op is captured on the next rising edge.
  task automatic run_op(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int          edges;
    logic        got;
    ctrl_MULT     = 1'b1;
    ctrl_signed   = sg;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_signed   = 1'($urandom);
    data_operandA = $urandom;
    data_operandB = $urandom;
    check({tag, ":busy_on"}, 64'(busy), 64'd1);
    p     = model_prod(sg, a, b);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 200) begin
      @(posedge clock);
      #1;
      edges++;
      got = data_resultRDY;
    end
    check({tag, ":rdy_seen"}, 64'(got), 64'd1);
    check({tag, ":latency"}, 64'(edges), 64'(model_lat(sg, b)));
    check({tag, ":lo"}, 64'(data_result), 64'(p[31:0]));
    check({tag, ":hi"}, 64'(data_result_hi), 64'(p[63:32]));
    check({tag, ":exc"}, 64'(data_exception), 64'(model_exc(sg, p)));
    check({tag, ":busy_off"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int          rdy_cnt;
    int          edges;
    logic        got;
    logic [63:0] p;

    // Reset state
    #12;
    check("reset:lo", 64'(data_result), 64'd0);
    check("reset:hi", 64'(data_result_hi), 64'd0);
    check("reset:flags", 64'({data_exception, data_resultRDY, busy}), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed corner cases
    run_op("s7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD);
    check("s7xm3:lo_const", 64'(data_result), 64'hFFFF_FFEB);
    check("s7xm3:hi_const", 64'(data_result_hi), 64'hFFFF_FFFF);
    @(posedge clock); #1;
    check("s7xm3:rdy_one_cycle", 64'(data_resultRDY), 64'd0);
    check("s7xm3:hold_lo", 64'(data_result), 64'hFFFF_FFEB);

    run_op("smin_xm1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("smin_xm1:exc_const", 64'(data_exception), 64'd1);
    run_op("u_max2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // back-to-back from DONE
    check("u_max2:hi_const", 64'(data_result_hi), 64'hFFFF_FFFE);
    run_op("s_m1sq", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("s_m1sq:exc_const", 64'(data_exception), 64'd0);
    run_op("s_maxpos2", 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_op("u_zero", 1'b0, 32'h0, 32'h0);
    run_op("u_msb_x2", 1'b0, 32'h8000_0000, 32'd2);
    run_op("s_b_maxpos", 1'b1, 32'd3, 32'h7FFF_FFFF);
    run_op("s_3x5", 1'b1, 32'd3, 32'd5);
    check("s_3x5:lo_const", 64'(data_result), 64'd15);
    @(posedge clock); #1;

    // Abort mid-op: only the restarted op may signal RDY
    rdy_cnt = 0;
    ctrl_MULT = 1'b1; ctrl_signed = 1'b1;
    data_operandA = 32'd3;
`ifdef MULT_EARLYOUT_EN
    data_operandB = 32'h5555_5555;
`else
    data_operandB = 32'd5;
`endif
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_cnt++;
    end
    ctrl_MULT = 1'b1; ctrl_signed = 1'b1;
    data_operandA = 32'hFFFF_FFFC; data_operandB = 32'd6;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    edges = 0; got = 1'b0;
    while (!got && edges < 200) begin
      @(posedge clock); #1;
      edges++;
      got = data_resultRDY;
      if (data_resultRDY) rdy_cnt++;
    end
    check("abort:latency", 64'(edges), 64'(model_lat(1'b1, 32'd6)));
    check("abort:lo", 64'(data_result), 64'hFFFF_FFE8);
    check("abort:hi", 64'(data_result_hi), 64'hFFFF_FFFF);
    repeat (30) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_cnt++;
    end
    check("abort:rdy_count", 64'(rdy_cnt), 64'd1);

    // Reset in the middle of an operation
    ctrl_MULT = 1'b1; ctrl_signed = 1'b0;
    data_operandA = 32'h1234_5678; data_operandB = 32'h9ABC_DEF0;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    check("midrst:lo", 64'(data_result), 64'd0);
    check("midrst:hi", 64'(data_result_hi), 64'd0);
    check("midrst:flags", 64'({data_exception, data_resultRDY, busy}), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY || busy) rdy_cnt++;
    end
    check("midrst:quiet_after", 64'(rdy_cnt), 64'd0);

    // Randomized operations, alternating idle gaps and back-to-back starts
    for (int i = 0; i < 24; i++) begin
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      sg = 1'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (i % 3 == 1) b = 32'($urandom_range(15, 0));
      if (i % 3 == 2) b = ~32'($urandom_range(15, 0));
      run_op("rnd", sg, a, b);
      if (i % 2 == 0) begin
        p = model_prod(sg, a, b);
        @(posedge clock); #1;
        check("rnd:rdy_low", 64'(data_resultRDY), 64'd0);
        check("rnd:hold_hi", 64'(data_result_hi), 64'(p[63:32]));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
